// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 interrupt/exception/RTI sequencer.
package lc3_pkg;

  typedef enum logic [4:0] {
    IDLE,
    E_PSR,
    E_SWAP,
    E_DEC1,
    E_WR1,
    E_PCS,
    E_DEC2,
    E_WR2,
    E_VEC,
    E_RDV,
    E_JMP,
    R_MAR,
    R_RD1,
    R_PC,
    R_INC1,
    R_RD2,
    R_PSR,
    R_INC2,
    R_SWAP
  } seq_state_t;

  localparam logic [2:0] SP_IDX     = 3'd6;

  localparam logic [1:0] VEC_INT    = 2'b00;
  localparam logic [1:0] VEC_PRIV   = 2'b01;

  localparam logic [1:0] SPMUX_SSP  = 2'd0;
  localparam logic [1:0] SPMUX_DEC  = 2'd1;
  localparam logic [1:0] SPMUX_INC  = 2'd2;
  localparam logic [1:0] SPMUX_USP  = 2'd3;

  localparam logic [1:0] PCMUX_BUS  = 2'b10;
  localparam logic [1:0] ALU_PASSA  = 2'b00;

endpackage

// File: rtl/lc3_int_sequencer.sv
// Drives LC-3 datapath controls for interrupt entry, privilege-exception entry and RTI
// while the main control FSM has handed over the datapath.
module lc3_int_sequencer
  import lc3_pkg::*;
#(
  parameter logic [2:0] SP_REG = SP_IDX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_int,
  input  logic       start_rti,
  input  logic       priv,
  input  logic       mem_ready,
  output logic       busy,
  output logic       done,
  output logic       priv_exc,
  output logic       enaALU,
  output logic       enaPC,
  output logic       enaMDR,
  output logic       enaPSR,
  output logic       enaPCM1,
  output logic       enaSP,
  output logic       enaVector,
  output logic       enaMARM,
  output logic       ldPC,
  output logic       ldIR,
  output logic       ldMAR,
  output logic       ldMDR,
  output logic       logicWE,
  output logic       ldCC,
  output logic       ldPriority,
  output logic       ldPriv,
  output logic       ldSavedUSP,
  output logic       ldSavedSSP,
  output logic [2:0] SR1,
  output logic [2:0] DR,
  output logic [1:0] aluControl,
  output logic [1:0] selPC,
  output logic [1:0] selSPMUX,
  output logic [1:0] selVectorMUX,
  output logic       selMDR,
  output logic       selPSRMUX,
  output logic       SetPriv,
  output logic       memWE
);

  seq_state_t state, state_nx;
  logic       is_exc;   // entry was triggered by RTI in user mode
  logic       priv_q;   // privilege mode at the moment the start was accepted

  logic       accept;
  assign accept = (state == IDLE) && (start_int || start_rti);

  // State register plus the per-sequence flags captured at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      is_exc <= 1'b0;
      priv_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        is_exc <= !start_int && start_rti && priv;
        priv_q <= priv;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_int)      state_nx = E_PSR;
        else if (start_rti) state_nx = priv ? E_PSR : R_MAR;
      end
      E_PSR:  state_nx = priv_q ? E_SWAP : E_DEC1;
      E_SWAP: state_nx = E_DEC1;
      E_DEC1: state_nx = E_WR1;
      E_WR1:  if (mem_ready) state_nx = E_PCS;
      E_PCS:  state_nx = E_DEC2;
      E_DEC2: state_nx = E_WR2;
      E_WR2:  if (mem_ready) state_nx = E_VEC;
      E_VEC:  state_nx = E_RDV;
      E_RDV:  if (mem_ready) state_nx = E_JMP;
      E_JMP:  state_nx = IDLE;
      R_MAR:  state_nx = R_RD1;
      R_RD1:  if (mem_ready) state_nx = R_PC;
      R_PC:   state_nx = R_INC1;
      R_INC1: state_nx = R_RD2;
      R_RD2:  if (mem_ready) state_nx = R_PSR;
      R_PSR:  state_nx = R_INC2;
      R_INC2: state_nx = priv ? R_SWAP : IDLE;
      R_SWAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = 1'b0;
    priv_exc     = (state != IDLE) && is_exc;
    enaALU       = 1'b0;
    enaPC        = 1'b0;
    enaMDR       = 1'b0;
    enaPSR       = 1'b0;
    enaPCM1      = 1'b0;
    enaSP        = 1'b0;
    enaVector    = 1'b0;
    enaMARM      = 1'b0;
    ldPC         = 1'b0;
    ldIR         = 1'b0;
    ldMAR        = 1'b0;
    ldMDR        = 1'b0;
    logicWE      = 1'b0;
    ldCC         = 1'b0;
    ldPriority   = 1'b0;
    ldPriv       = 1'b0;
    ldSavedUSP   = 1'b0;
    ldSavedSSP   = 1'b0;
    SR1          = '0;
    DR           = '0;
    aluControl   = '0;
    selPC        = '0;
    selSPMUX     = '0;
    selVectorMUX = '0;
    selMDR       = 1'b0;
    selPSRMUX    = 1'b0;
    SetPriv      = 1'b0;
    memWE        = 1'b0;
    unique case (state)
      IDLE: ;
      E_PSR: begin
        enaPSR     = 1'b1;
        ldMDR      = 1'b1;
        selPSRMUX  = 1'b1;
        ldPriv     = 1'b1;
        ldPriority = !is_exc;
      end
      E_SWAP: begin
        ldSavedUSP = 1'b1;
        SR1        = SP_REG;
        selSPMUX   = SPMUX_SSP;
        enaSP      = 1'b1;
        logicWE    = 1'b1;
        DR         = SP_REG;
      end
      E_DEC1, E_DEC2: begin
        selSPMUX = SPMUX_DEC;
        SR1      = SP_REG;
        enaSP    = 1'b1;
        ldMAR    = 1'b1;
        logicWE  = 1'b1;
        DR       = SP_REG;
      end
      E_WR1, E_WR2: begin
        selMDR = 1'b1;
        memWE  = 1'b1;
      end
      E_PCS: begin
        enaPCM1 = 1'b1;
        ldMDR   = 1'b1;
      end
      E_VEC: begin
        enaVector    = 1'b1;
        ldMAR        = 1'b1;
        selVectorMUX = is_exc ? VEC_PRIV : VEC_INT;
      end
      E_RDV, R_RD1, R_RD2: begin
        selMDR = 1'b1;
        ldMDR  = mem_ready;
      end
      E_JMP: begin
        enaMDR = 1'b1;
        selPC  = PCMUX_BUS;
        ldPC   = 1'b1;
        done   = 1'b1;
      end
      R_MAR: begin
        SR1        = SP_REG;
        aluControl = ALU_PASSA;
        enaALU     = 1'b1;
        ldMAR      = 1'b1;
      end
      R_PC: begin
        enaMDR = 1'b1;
        selPC  = PCMUX_BUS;
        ldPC   = 1'b1;
      end
      R_INC1, R_INC2: begin
        selSPMUX = SPMUX_INC;
        SR1      = SP_REG;
        enaSP    = 1'b1;
        logicWE  = 1'b1;
        DR       = SP_REG;
        ldMAR    = (state == R_INC1);
        done     = (state == R_INC2) && !priv;
      end
      R_PSR: begin
        enaMDR     = 1'b1;
        selPSRMUX  = 1'b0;
        ldCC       = 1'b1;
        ldPriority = 1'b1;
        ldPriv     = 1'b1;
      end
      R_SWAP: begin
        ldSavedSSP = 1'b1;
        SR1        = SP_REG;
        selSPMUX   = SPMUX_USP;
        enaSP      = 1'b1;
        logicWE    = 1'b1;
        DR         = SP_REG;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_int_sequencer.sv
// Bench: drives the sequencer against a small LC-3 datapath/memory environment and
// compares the architectural outcome with an ISA-level model of interrupt entry and RTI.
module tb_lc3_int_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_int, start_rti, priv, mem_ready;
  logic       busy, done, priv_exc;
  logic       enaALU, enaPC, enaMDR, enaPSR, enaPCM1, enaSP, enaVector, enaMARM;
  logic       ldPC, ldIR, ldMAR, ldMDR, logicWE, ldCC, ldPriority, ldPriv, ldSavedUSP, ldSavedSSP;
  logic [2:0] SR1, DR;
  logic [1:0] aluControl, selPC, selSPMUX, selVectorMUX;
  logic       selMDR, selPSRMUX, SetPriv, memWE;

  always #5 clk = ~clk;

  lc3_int_sequencer #(.SP_REG(3'd6)) dut (
    .clk(clk), .rst(rst), .start_int(start_int), .start_rti(start_rti), .priv(priv),
    .mem_ready(mem_ready), .busy(busy), .done(done), .priv_exc(priv_exc),
    .enaALU(enaALU), .enaPC(enaPC), .enaMDR(enaMDR), .enaPSR(enaPSR), .enaPCM1(enaPCM1),
    .enaSP(enaSP), .enaVector(enaVector), .enaMARM(enaMARM),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .logicWE(logicWE), .ldCC(ldCC),
    .ldPriority(ldPriority), .ldPriv(ldPriv), .ldSavedUSP(ldSavedUSP), .ldSavedSSP(ldSavedSSP),
    .SR1(SR1), .DR(DR), .aluControl(aluControl), .selPC(selPC), .selSPMUX(selSPMUX),
    .selVectorMUX(selVectorMUX), .selMDR(selMDR), .selPSRMUX(selPSRMUX), .SetPriv(SetPriv),
    .memWE(memWE)
  );

  localparam logic [2:0] INT_PRI = 3'd4;

  // Datapath environment state
  logic [15:0] R [8];
  logic [15:0] PC, PSR, USP, SSP, MAR, MDR;
  logic [7:0]  INTV;
  logic [15:0] mem [65536];

  logic [15:0] nR [8];
  logic [15:0] nPC, nPSR, nUSP, nSSP, nMAR, nMDR;
  logic        wr_en;
  logic [15:0] wr_a, wr_d;

  int n_checks = 0;
  int n_err    = 0;
  int waits[$];
  bit in_acc;
  int cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] outs_vec();
    return {busy, done, priv_exc, enaALU, enaPC, enaMDR, enaPSR, enaPCM1, enaSP, enaVector,
            enaMARM, ldPC, ldIR, ldMAR, ldMDR, logicWE, ldCC, ldPriority, ldPriv, ldSavedUSP,
            ldSavedSSP, SR1, DR, aluControl, selPC, selSPMUX, selVectorMUX, selMDR, selPSRMUX,
            SetPriv, memWE};
  endfunction

  task automatic dp_compute();
    logic [15:0] bus, spm;
    case (selSPMUX)
      2'd0:    spm = SSP;
      2'd1:    spm = R[SR1] - 16'd1;
      2'd2:    spm = R[SR1] + 16'd1;
      default: spm = USP;
    endcase
    bus = 16'h0000;
    if (enaALU)    bus = (aluControl == 2'b00) ? R[SR1] : 16'h0000;
    if (enaPC)     bus = PC;
    if (enaMDR)    bus = MDR;
    if (enaPSR)    bus = PSR;
    if (enaPCM1)   bus = PC - 16'd1;
    if (enaSP)     bus = spm;
    if (enaVector) bus = (selVectorMUX == 2'b00) ? {8'h01, INTV} : 16'h0100;
    for (int i = 0; i < 8; i++) nR[i] = R[i];
    nPC = PC; nPSR = PSR; nUSP = USP; nSSP = SSP; nMAR = MAR; nMDR = MDR;
    wr_en = 1'b0; wr_a = MAR; wr_d = MDR;
    if (ldMAR)   nMAR = bus;
    if (ldMDR)   nMDR = selMDR ? mem[MAR] : bus;
    if (memWE && mem_ready) wr_en = 1'b1;
    if (ldPC)    nPC = (selPC == 2'b10) ? bus : PC + 16'd1;
    if (logicWE) nR[DR] = bus;
    if (ldSavedUSP) nUSP = R[SR1];
    if (ldSavedSSP) nSSP = R[SR1];
    if (ldCC)       nPSR[2:0]  = bus[2:0];
    if (ldPriority) nPSR[10:8] = selPSRMUX ? INT_PRI : bus[10:8];
    if (ldPriv)     nPSR[15]   = selPSRMUX ? SetPriv : bus[15];
  endtask

  task automatic dp_apply();
    for (int i = 0; i < 8; i++) R[i] = nR[i];
    PC = nPC; PSR = nPSR; USP = nUSP; SSP = nSSP; MAR = nMAR; MDR = nMDR;
    if (wr_en) mem[wr_a] = wr_d;
    priv = PSR[15];
  endtask

  // Memory handshake: each access waits the next queued number of cycles before ready
  task automatic drive_mem();
    if (selMDR) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        cnt = (waits.size() != 0) ? waits.pop_front() : 0;
      end
      mem_ready = (cnt == 0);
      if (cnt != 0) cnt--;
      if (mem_ready) in_acc = 1'b0;
    end else begin
      in_acc = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic setup(input logic [15:0] r6, ssp, usp, pc, psr, input logic [7:0] intv);
    for (int i = 0; i < 8; i++) R[i] = 16'($urandom);
    R[6] = r6; SSP = ssp; USP = usp; PC = pc; PSR = psr; INTV = intv;
    MAR = 16'($urandom); MDR = 16'($urandom);
    priv = psr[15];
  endtask

  task automatic issue(input int kind);
    @(negedge clk);
    start_int = (kind != 1);
    start_rti = (kind != 0);
    @(posedge clk);
    #1;
    start_int = 1'b0;
    start_rti = 1'b0;
  endtask

  // kind: 0 interrupt, 1 RTI, 2 both starts together
  task automatic run_txn(input int kind, input int w0, input int w1, input int w2);
    bit          entry, exc, prev_stall;
    int          base, exp_done, cyc, done_at, ena_bad, busy_bad, pexc_bad, frz_bad;
    logic [15:0] sp, a1, a2, eR6, ePC, ePSR, eUSP, eSSP, psr0, pc0, np, vaddr;
    logic [38:0] o, prev_o, msk;
    entry = (kind != 1) || PSR[15];
    exc   = (kind == 1) && PSR[15];
    psr0 = PSR; pc0 = PC; eUSP = USP; eSSP = SSP;
    a1 = 16'h0; a2 = 16'h0;
    if (entry) begin
      sp = PSR[15] ? SSP : R[6];
      if (PSR[15]) eUSP = R[6];
      a1 = sp - 16'd1; a2 = sp - 16'd2;
      eR6 = a2;
      ePSR = PSR; ePSR[15] = 1'b0;
      if (!exc) ePSR[10:8] = INT_PRI;
      vaddr = exc ? 16'h0100 : {8'h01, INTV};
      ePC = mem[vaddr];
      base = 9 + int'(PSR[15]);
    end else begin
      sp = R[6];
      ePC = mem[sp];
      np = mem[sp + 16'd1];
      ePSR = PSR; ePSR[15] = np[15]; ePSR[10:8] = np[10:8]; ePSR[2:0] = np[2:0];
      eR6 = sp + 16'd2;
      if (np[15]) begin eSSP = eR6; eR6 = USP; end
      base = 7 + int'(np[15]);
    end
    waits.delete();
    waits.push_back(w0); waits.push_back(w1);
    if (entry) waits.push_back(w2);
    exp_done = base + w0 + w1 + (entry ? w2 : 0);
    in_acc = 1'b0; cnt = 0;
    ena_bad = 0; busy_bad = 0; pexc_bad = 0; frz_bad = 0; done_at = 0; cyc = 0;
    prev_stall = 1'b0; prev_o = '0;
    msk = '1; msk[24] = 1'b0;   // ldMDR legitimately rises in the ready cycle of a read
    issue(kind);
    while (cyc < 60 && done_at == 0) begin
      @(negedge clk);
      cyc++;
      start_int = ($urandom_range(0, 3) == 0);
      start_rti = ($urandom_range(0, 3) == 0);
      drive_mem();
      #1;
      o = outs_vec();
      if ($countones({enaALU, enaPC, enaMDR, enaPSR, enaPCM1, enaSP, enaVector, enaMARM}) > 1)
        ena_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (priv_exc !== exc) pexc_bad++;
      if (prev_stall && ((o & msk) !== (prev_o & msk))) frz_bad++;
      prev_stall = selMDR && !mem_ready;
      prev_o = o;
      if (done === 1'b1) begin
        done_at = cyc;
        start_int = 1'b1;
      end
      dp_compute();
      @(posedge clk);
      #1;
      dp_apply();
    end
    start_int = 1'b0;
    start_rti = 1'b0;
    @(negedge clk);
    #1;
    check("idle_after_done", 64'(outs_vec()), 64'h0);
    check("done_cycle", done_at, exp_done);
    check("ena_onehot", ena_bad, 0);
    check("busy_held", busy_bad, 0);
    check("priv_exc", pexc_bad, 0);
    check("stall_freeze", frz_bad, 0);
    check("pc", PC, ePC);
    check("psr", PSR, ePSR);
    check("r6", R[6], eR6);
    check("saved_usp", USP, eUSP);
    check("saved_ssp", SSP, eSSP);
    if (entry) begin
      check("push_psr", mem[a1], psr0);
      check("push_pc", mem[a2], pc0 - 16'd1);
    end
  endtask

  task automatic run_reset_mid();
    setup(16'h4000, 16'h3000, 16'h0000, 16'h3005, 16'h8002, 8'h80);
    mem[16'h0180] = 16'h1200;
    waits.delete(); in_acc = 1'b0; cnt = 0;
    issue(0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      drive_mem();
      #1;
      dp_compute();
      if (c < 6) begin
        @(posedge clk);
        #1;
        dp_apply();
      end
    end
    check("dec2_controls", {logicWE, ldMAR, enaSP, selSPMUX}, 5'b11101);
    rst = 1'b0;
    #1;
    check("async_reset_outs", 64'(outs_vec()), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("idle_after_reset", 64'(outs_vec()), 64'h0);
  endtask

  initial begin
    logic [15:0] r6, ssp;
    int          kind;
    rst = 1'b0; start_int = 1'b0; start_rti = 1'b0; priv = 1'b0; mem_ready = 1'b0;
    #2;
    check("reset_outs", 64'(outs_vec()), 64'h0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Interrupt from user mode
    setup(16'h4000, 16'h3000, 16'h0000, 16'h3005, 16'h8002, 8'h80);
    mem[16'h0180] = 16'h1200;
    run_txn(0, 0, 0, 0);
    // Interrupt from supervisor mode
    setup(16'h2FF0, 16'h3000, 16'h4000, 16'h3005, 16'h0002, 8'h80);
    run_txn(0, 0, 0, 0);
    // RTI returning to user mode
    setup(16'h2FFE, 16'h1111, 16'h4000, 16'h1200, 16'h0001, 8'h80);
    mem[16'h2FFE] = 16'h3004; mem[16'h2FFF] = 16'h8002;
    run_txn(1, 0, 0, 0);
    // RTI from user mode becomes a privilege exception
    setup(16'h4000, 16'h3000, 16'h0000, 16'h3005, 16'h8302, 8'h80);
    mem[16'h0100] = 16'h0A00;
    run_txn(1, 0, 0, 0);
    // Three-cycle stall on the first push
    setup(16'h4000, 16'h3000, 16'h0000, 16'h3005, 16'h8002, 8'h80);
    run_txn(0, 3, 0, 0);
    // Both starts together: interrupt path wins
    setup(16'h2F00, 16'h3000, 16'h4000, 16'h3100, 16'h0005, 8'h42);
    mem[16'h0142] = 16'h5555;
    run_txn(2, 1, 0, 2);

    run_reset_mid();

    for (int t = 0; t < 40; t++) begin
      r6  = 16'h2800 + 16'($urandom_range(0, 16'h0FFF));
      ssp = 16'h3800 + 16'($urandom_range(0, 16'h07FF));
      kind = $urandom_range(0, 2);
      setup(r6, ssp, 16'h4000 + 16'($urandom_range(0, 16'h0FFF)), 16'($urandom),
            16'($urandom), 8'($urandom));
      mem[{8'h01, INTV}] = 16'($urandom);
      mem[16'h0100]      = 16'($urandom);
      mem[r6]            = 16'($urandom);
      mem[r6 + 16'd1]    = 16'($urandom);
      run_txn(kind, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
